// File: rtl/sp_fpu_seq_pkg.sv
// Shared encodings for the sequential single-precision FPU.
// Imported by the FPU datapath and by its initiators.
package sp_fpu_seq_pkg;

    typedef enum logic [1:0] {
        OP_MUL = 2'd0,
        OP_DIV = 2'd1,
        OP_ADD = 2'd2,
        OP_SUB = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        ALIGN,
        ADDSUB,
        MULIT,
        DIVIT,
        NORM,
        DONE
    } state_e;

    localparam logic [31:0] QNAN      = 32'h7FC00000;
    localparam int          MUL_ITERS = 24;
    localparam int          DIV_ITERS = 25;

endpackage

// File: rtl/sp_lzc48.sv
// Combinational 48-bit leading-zero counter.
// Returns 48 when the input is all zeros.
module sp_lzc48 (
    input  logic [47:0] x,
    output logic [5:0]  lz
);

    always_comb begin
        lz = 6'd48;
        for (int i = 0; i < 48; i++) begin
            if (x[i]) lz = 6'(47 - i);
        end
    end

endmodule

// File: rtl/sp_fpu_seq.sv
// Multi-cycle IEEE-754 single FPU: mult, div, add, sub.
// Truncating rounding, denormals flushed to zero.
module sp_fpu_seq
    import sp_fpu_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  op,
    input  logic        go,
    output logic [31:0] d,
    output logic        done
);

    state_e state, state_nx;
    op_e    rop;
    logic [31:0] ra, rb, res;
    logic        sa, sb, rsign;
    logic signed [9:0] ea, eb, rexp;
    logic [23:0] ma, mb;
    logic [47:0] acc;
    logic [24:0] rem;
    logic [4:0]  cnt;

    logic [7:0]  xa, xb;
    logic        za, zb, ia, ib, na, nb;
    logic        u_sa, u_sb, sx;
    logic signed [9:0] u_ea, u_eb;
    logic [23:0] u_ma, u_mb;

    assign xa   = ra[30:23];
    assign xb   = rb[30:23];
    assign za   = (xa == 8'd0);
    assign zb   = (xb == 8'd0);
    assign ia   = (xa == 8'hFF) && (ra[22:0] == 23'd0);
    assign ib   = (xb == 8'hFF) && (rb[22:0] == 23'd0);
    assign na   = (xa == 8'hFF) && (ra[22:0] != 23'd0);
    assign nb   = (xb == 8'hFF) && (rb[22:0] != 23'd0);
    assign u_sa = ra[31];
    assign u_sb = rb[31] ^ (rop == OP_SUB);
    assign sx   = ra[31] ^ rb[31];
    assign u_ea = za ? 10'sd0 : $signed({2'b00, xa});
    assign u_eb = zb ? 10'sd0 : $signed({2'b00, xb});
    assign u_ma = za ? 24'd0 : {1'b1, ra[22:0]};
    assign u_mb = zb ? 24'd0 : {1'b1, rb[22:0]};

    logic        spec;
    logic [31:0] spec_val;

    always_comb begin
        spec     = 1'b1;
        spec_val = QNAN;
        if (!(na || nb)) begin
            case (rop)
                OP_MUL: begin
                    if (!((ia && zb) || (za && ib))) begin
                        spec     = ia || ib;
                        spec_val = {sx, 8'hFF, 23'd0};
                    end
                end
                OP_DIV: begin
                    if (!((za && zb) || (ia && ib))) begin
                        spec     = zb || ia || ib;
                        spec_val = ib ? {sx, 31'd0} : {sx, 8'hFF, 23'd0};
                    end
                end
                default: begin
                    if (!(ia && ib && (u_sa != u_sb))) begin
                        spec     = ia || ib;
                        spec_val = {ia ? u_sa : u_sb, 8'hFF, 23'd0};
                    end
                end
            endcase
        end
    end

    logic signed [9:0] ediff;
    logic [9:0]  sh;
    logic [24:0] s_sum, s_dab, s_dba, m_sum;
    logic        d_ge;
    logic [23:0] d_rem;

    assign ediff = ea - eb;
    assign sh    = ediff[9] ? $unsigned(-ediff) : $unsigned(ediff);
    assign s_sum = {1'b0, ma} + {1'b0, mb};
    assign s_dab = {1'b0, ma} - {1'b0, mb};
    assign s_dba = {1'b0, mb} - {1'b0, ma};
    assign m_sum = {1'b0, acc[47:24]} + {1'b0, mb[0] ? ma : 24'd0};
    assign d_ge  = (rem >= {1'b0, mb});
    assign d_rem = d_ge ? 24'(rem - {1'b0, mb}) : rem[23:0];

    // acc bit 47 carries weight 2^(rexp-127) for every operation
    logic [5:0]  lz;
    logic [22:0] n_frac;
    logic signed [9:0] n_exp;
    logic [31:0] n_val;

    sp_lzc48 u_lzc (
        .x  (acc),
        .lz (lz)
    );

    assign n_frac = 23'((acc << lz) >> 24);
    assign n_exp  = rexp - $signed({4'b0000, lz});

    always_comb begin
        n_val = {rsign, n_exp[7:0], n_frac};
        if (acc == 48'd0)
            n_val = {rsign & ~rop[1], 31'd0};
        else if (n_exp >= 10'sd255)
            n_val = {rsign, 8'hFF, 23'd0};
        else if (n_exp <= 10'sd0)
            n_val = {rsign, 31'd0};
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (go) state_nx = UNPACK;
            UNPACK: begin
                if (spec)              state_nx = DONE;
                else if (rop == OP_MUL) state_nx = MULIT;
                else if (rop == OP_DIV) state_nx = DIVIT;
                else                   state_nx = ALIGN;
            end
            ALIGN:  state_nx = ADDSUB;
            ADDSUB: state_nx = NORM;
            MULIT:  if (cnt == 5'(MUL_ITERS - 1)) state_nx = NORM;
            DIVIT:  if (cnt == 5'(DIV_ITERS - 1)) state_nx = NORM;
            NORM:   state_nx = DONE;
            DONE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d <= '0; done <= 1'b0; res <= '0;
            ra <= '0; rb <= '0; rop <= OP_MUL;
            sa <= 1'b0; sb <= 1'b0; rsign <= 1'b0;
            ea <= '0; eb <= '0; rexp <= '0;
            ma <= '0; mb <= '0; acc <= '0;
            rem <= '0; cnt <= '0;
        end else begin
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (go) begin
                        ra  <= a;
                        rb  <= b;
                        rop <= op_e'(op);
                    end
                end
                UNPACK: begin
                    sa <= u_sa; sb <= u_sb; rsign <= sx;
                    ea <= u_ea; eb <= u_eb;
                    ma <= u_ma; mb <= u_mb;
                    rem <= {1'b0, u_ma};
                    acc <= '0; cnt <= '0; res <= spec_val;
                    rexp <= (rop == OP_DIV) ? u_ea - u_eb + 10'sd150
                                            : u_ea + u_eb - 10'sd126;
                end
                ALIGN: begin
                    if (!ediff[9]) begin
                        mb   <= mb >> sh;
                        rexp <= ea + 10'sd1;
                    end else begin
                        ma   <= ma >> sh;
                        rexp <= eb + 10'sd1;
                    end
                end
                ADDSUB: begin
                    if (sa == sb) begin
                        acc <= {s_sum, 23'd0}; rsign <= sa;
                    end else if (ma >= mb) begin
                        acc <= {s_dab, 23'd0}; rsign <= sa;
                    end else begin
                        acc <= {s_dba, 23'd0}; rsign <= sb;
                    end
                end
                MULIT: begin
                    acc <= {m_sum, acc[23:1]};
                    mb  <= mb >> 1;
                    cnt <= cnt + 5'd1;
                end
                DIVIT: begin
                    rem <= {d_rem, 1'b0};
                    acc <= {acc[46:0], d_ge};
                    cnt <= cnt + 5'd1;
                end
                NORM: res <= n_val;
                DONE: d <= res;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sp_fpu_seq.sv
// Scoreboard bench for sp_fpu_seq: results and done latency.
// Expected values come from hand-derived IEEE constants.
module tb_sp_fpu_seq;
    import sp_fpu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a, b, d;
    logic [1:0]  op;
    logic        go, done;

    always #5 clk = ~clk;

    sp_fpu_seq dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .op    (op),
        .go    (go),
        .d     (d),
        .done  (done)
    );

    typedef struct {
        logic [31:0] d;
        int          lat;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %08h want %08h", tag, got, want);
        end
    endtask

    task automatic run(input logic [31:0] ia, input logic [31:0] ib,
                       input logic [1:0] iop, input logic [31:0] ed,
                       input int elat, input string tag,
                       input int glitch = 0);
        int   lat;
        exp_t e;
        sb_q.push_back('{d: ed, lat: elat, tag: tag});
        @(negedge clk);
        a = ia; b = ib; op = iop; go = 1'b1;
        @(posedge clk); #1;
        go  = 1'b0;
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (k == glitch) begin
                go = 1'b1; a = 32'h12345678; op = OP_ADD;
            end else begin
                go = 1'b0;
            end
            if (done) begin
                lat = k;
                break;
            end
        end
        e = sb_q.pop_front();
        check({e.tag, "/d"}, d, e.d);
        check({e.tag, "/lat"}, 32'(lat), 32'(e.lat));
        @(posedge clk); #1;
        check({e.tag, "/pulse"}, {31'd0, done}, 32'd0);
        check({e.tag, "/hold"}, d, e.d);
    endtask

    initial begin
        reset = 1'b1; go = 1'b0; a = '0; b = '0; op = '0;
        #12;
        check("rst/d", d, 32'd0);
        check("rst/done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run(32'h3F800000, 32'h3F800000, OP_ADD, 32'h40000000, 5, "add1+1");
        run(32'h3F800000, 32'h3F800000, OP_SUB, 32'h00000000, 5, "sub1-1");
        run(32'h40400000, 32'hBF800000, OP_ADD, 32'h40000000, 5, "add3-1");
        run(32'h7F7FFFFF, 32'h7F7FFFFF, OP_ADD, 32'h7F800000, 5, "addovf");
        run(32'h3FC00000, 32'h40000000, OP_MUL, 32'h40400000, 27, "mul1.5x2");
        run(32'h7F7FFFFF, 32'h40000000, OP_MUL, 32'h7F800000, 27, "mulovf");
        run(32'hC0000000, 32'h40400000, OP_MUL, 32'hC0C00000, 27, "mul-2x3");
        run(32'h00800000, 32'h3F000000, OP_MUL, 32'h00000000, 27, "mulunf");
        run(32'h3F800000, 32'h40400000, OP_DIV, 32'h3EAAAAAA, 28, "div1/3");
        run(32'h40C00000, 32'h40000000, OP_DIV, 32'h40400000, 28, "div6/2");
        run(32'h3F800000, 32'h00000000, OP_DIV, 32'h7F800000, 2, "div1/0");
        run(32'h00000000, 32'h00000000, OP_DIV, QNAN, 2, "div0/0");
        run(32'h3F800000, 32'hFF800000, OP_DIV, 32'h80000000, 2, "div1/-inf");
        run(32'h7F800000, 32'h00000000, OP_MUL, QNAN, 2, "mulinf0");
        run(32'h7F800000, 32'h3F800000, OP_ADD, 32'h7F800000, 2, "addinf");
        run(32'h7F800000, 32'h7F800000, OP_SUB, QNAN, 2, "subinfinf");
        for (int i = 0; i < 4; i++)
            run(32'h7FC00001, 32'h3F800000, 2'(i), QNAN, 2,
                $sformatf("nan_op%0d", i));

        run(32'h3FC00000, 32'h40000000, OP_MUL, 32'h40400000, 27,
            "mulglitch", 5);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("stray", {31'd0, done}, 32'd0);
        end

        @(negedge clk);
        a = 32'h3F800000; b = 32'h40400000; op = OP_DIV; go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst/d", d, 32'd0);
        check("midrst/done", {31'd0, done}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("midrst/hold", {31'd0, done}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        run(32'h3F800000, 32'h3F800000, OP_ADD, 32'h40000000, 5, "postrst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sp_fpu_seq.md
SP_FPU_SEQ -- requirements
Module: sp_fpu_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-002 SHALL have port reset, input, 1 bit, asynchronous, active-high.
REQ-003 SHALL have port a, input, 32 bits, IEEE-754 single operand A.
REQ-004 SHALL have port b, input, 32 bits, IEEE-754 single operand B.
REQ-005 SHALL have port op, input, 2 bits: 0=MULT, 1=DIV, 2=ADD (a+b), 3=SUB (a-b).
REQ-006 SHALL have port go, input, 1 bit, start request, level-sampled in IDLE.
REQ-007 SHALL have port d, output, 32 bits, registered result.
REQ-008 SHALL have port done, output, 1 bit, one-cycle result-valid pulse.

Function
REQ-009 SHALL sample a, b and op into internal registers on the rising edge where state=IDLE and go=1, then enter UNPACK.
REQ-010 SHALL ignore go in every state other than IDLE.
REQ-011 SHALL accept go=1 still high in the IDLE cycle after DONE as a new request; the initiator drops go by the done cycle.
REQ-012 SHALL use states IDLE, UNPACK, ALIGN, ADDSUB, MULIT, DIVIT, NORM and DONE.
REQ-013 SHALL in UNPACK flush denormal operands to signed zero and detect special cases; a special case goes straight to DONE.
REQ-014 SHALL resolve special cases as: any NaN operand -> 0x7FC00000; inf-inf (effective) -> 0x7FC00000; inf*0 -> 0x7FC00000; 0/0 and inf/inf -> 0x7FC00000; x/0 (x nonzero) -> inf with sign a^b; inf op finite -> correctly signed inf; finite/inf -> signed zero.
REQ-015 SHALL run ADD/SUB as UNPACK -> ALIGN (barrel right-shift of the smaller operand, sticky discarded) -> ADDSUB -> NORM -> DONE.
REQ-016 SHALL run MULT as UNPACK -> MULIT (24 shift-add cycles on 24-bit mantissas into a 48-bit product) -> NORM -> DONE.
REQ-017 SHALL run DIV as UNPACK -> DIVIT (25 restoring-division cycles, one quotient bit each) -> NORM -> DONE.
REQ-018 SHALL assert done in the cycle that is N edges after the go-sampling edge: N=5 for ADD/SUB, 27 for MULT, 28 for DIV, 2 for special cases.
REQ-019 SHALL normalize in NORM in one cycle using a leading-zero count, adjusting the exponent.
REQ-020 SHALL round by truncation (toward zero).
REQ-021 SHALL produce signed inf when the biased exponent is 255 or more after NORM.
REQ-022 SHALL produce signed zero, flushing the denormal, when the biased exponent is 0 or less after NORM.
REQ-023 SHALL produce an exact-zero ADD/SUB result as +0 (0x00000000).
REQ-024 SHALL hold d stable from DONE until the next DONE, and assert done only in DONE, then return to IDLE.

Reset
REQ-025 SHALL on reset, at any time including mid-operation, force state=IDLE, d=0x00000000 and done=0 immediately; the next operation follows REQ-009.

Structure
REQ-026 SHALL place the op encodings, the QNAN constant 0x7FC00000, the state encoding and the iteration counts 24 and 25 in a shared package also used by the initiator.
REQ-027 SHALL instantiate one sub-module sp_lzc48: a combinational 48-bit leading-zero counter used by NORM.
REQ-028 SHALL use a single iteration counter of 5 bits shared by MULIT and DIVIT.

Verification
REQ-029 SHALL cover ADD 0x3F800000+0x3F800000 -> d=0x40000000, done pulse exactly 5 cycles after go; then SUB of the same operands -> 0x00000000.
REQ-030 SHALL cover MULT 0x3FC00000*0x40000000 -> 0x40400000 at cycle 27, and MULT 0x7F7FFFFF*0x40000000 -> 0x7F800000.
REQ-031 SHALL cover DIV 0x3F800000/0x40400000 -> 0x3EAAAAAA (truncated) at cycle 28, and DIV 0x3F800000/0x00000000 -> 0x7F800000 at cycle 2.
REQ-032 SHALL cover special cases: NaN operand 0x7FC00001 with any op -> 0x7FC00000; 0x7F800000 SUB 0x7F800000 -> 0x7FC00000.
REQ-033 SHALL cover underflow: MULT 0x00800000*0x3F000000 -> 0x00000000.
REQ-034 SHALL cover handshake: go pulsed during MULIT is ignored; reset at cycle 10 of a DIV -> done stays 0, d=0; a new ADD then completes normally in 5 cycles.
